// File: rtl/peripheral_controller_pkg.sv
// Shared definitions for the peripheral controller.
// Holds the bus address map, the seven-segment codes (active-high, {g,f,e,d,c,b,a}),
// the keypad candidate record and small decode helpers.
package peripheral_controller_pkg;

    localparam logic [3:0] ADDR_KEY  = 4'h0;
    localparam logic [3:0] ADDR_DISP = 4'h4;

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_MINUS = 7'h40;

    // One keypad observation: a closed key and its code, code forced to 0 when not valid
    // so that equal observations always compare equal.
    typedef struct packed {
        logic       valid;
        logic [3:0] code;
    } key_cand_t;

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] seg;
        case (digit)
            4'd0:    seg = 7'h3F;
            4'd1:    seg = 7'h06;
            4'd2:    seg = 7'h5B;
            4'd3:    seg = 7'h4F;
            4'd4:    seg = 7'h66;
            4'd5:    seg = 7'h6D;
            4'd6:    seg = 7'h7D;
            4'd7:    seg = 7'h07;
            4'd8:    seg = 7'h7F;
            4'd9:    seg = 7'h6F;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Index of the lowest closed column; only meaningful when any bit is set.
    function automatic logic [1:0] lowest_col(input logic [3:0] cols);
        logic [1:0] idx;
        if (cols[0])      idx = 2'd0;
        else if (cols[1]) idx = 2'd1;
        else if (cols[2]) idx = 2'd2;
        else              idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/peripheral_controller_keypad_scanner.sv
// 4x4 matrix keypad scanner with column synchroniser and debounce.
// Ports:
//   clk      system clock
//   reset    synchronous active-low reset
//   cols     column sense, active-high, asynchronous to clk
//   rows     one-hot row drive, active-high, registered
//   key_reg  debounced key: {valid, 3'b000, code}, code = row*4 + col
module peripheral_controller_keypad_scanner
    import peripheral_controller_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] cols,
    output logic [3:0] rows,
    output logic [7:0] key_reg
);

    localparam int unsigned DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_SCANS);

    logic [DIV_W-1:0] div_cnt;
    logic [1:0]       row_idx;
    logic [3:0]       cols_meta;
    logic [3:0]       cols_sync;
    key_cand_t        scan_acc;
    key_cand_t        last_cand;
    logic [CNT_W-1:0] stable_cnt;

    logic             row_end;
    logic             scan_end;
    key_cand_t        row_cand;
    key_cand_t        scan_next;
    logic [CNT_W-1:0] cnt_next;

    always_comb begin
        // Columns are sampled at the end of each row period, long after the
        // two-flop synchroniser has caught up with the newly driven row.
        row_end        = (div_cnt == DIV_LAST);
        scan_end       = row_end && (row_idx == 2'd3);
        row_cand.valid = |cols_sync;
        row_cand.code  = row_cand.valid ? {row_idx, lowest_col(cols_sync)} : 4'd0;

        // Rows are visited in ascending order, so the first hit in a scan already
        // carries the lowest code; later rows never override it.
        if (row_idx == 2'd0)     scan_next = row_cand;
        else if (scan_acc.valid) scan_next = scan_acc;
        else                     scan_next = row_cand;

        if (scan_next != last_cand)   cnt_next = CNT_W'(1);
        else if (stable_cnt == CNT_MAX) cnt_next = CNT_MAX;
        else                          cnt_next = stable_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt    <= '0;
            row_idx    <= 2'd0;
            rows       <= 4'b0001;
            cols_meta  <= 4'b0000;
            cols_sync  <= 4'b0000;
            scan_acc   <= '0;
            last_cand  <= '0;
            stable_cnt <= '0;
            key_reg    <= 8'h00;
        end else begin
            cols_meta <= cols;
            cols_sync <= cols_meta;
            if (row_end) begin
                div_cnt  <= '0;
                row_idx  <= row_idx + 2'd1;
                rows     <= {rows[2:0], rows[3]};
                scan_acc <= scan_next;
                if (scan_end) begin
                    last_cand  <= scan_next;
                    stable_cnt <= cnt_next;
                    if (cnt_next == CNT_MAX) begin
                        key_reg <= scan_next.valid ? {1'b1, 3'b000, scan_next.code} : 8'h00;
                    end
                end
            end else begin
                div_cnt <= div_cnt + DIV_W'(1);
            end
        end
    end

endmodule

// File: rtl/peripheral_controller.sv
// Memory-mapped peripheral: signed decimal 7-segment display plus keypad.
// Ports:
//   clk, reset         system clock, synchronous active-low reset
//   address, din       bus word address and write data
//   writeEnable        bus write strobe
//   dout               registered read data (addr 0: key, addr 4: display low byte)
//   hex0..hex9         decimal digits, LSD first, active-low {g,f,e,d,c,b,a}
//   hex10              sign digit, active-low
//   dot                decimal point, active-low, held off
//   rows, cols         keypad row drive / column sense
module peripheral_controller
    import peripheral_controller_pkg::*;
#(
    parameter int unsigned SCAN_DIV       = 1000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  address,
    input  logic [31:0] din,
    input  logic        writeEnable,
    output logic [7:0]  dout,
    output logic [6:0]  hex0,
    output logic [6:0]  hex1,
    output logic [6:0]  hex2,
    output logic [6:0]  hex3,
    output logic [6:0]  hex4,
    output logic [6:0]  hex5,
    output logic [6:0]  hex6,
    output logic [6:0]  hex7,
    output logic [6:0]  hex8,
    output logic [6:0]  hex9,
    output logic [6:0]  hex10,
    output logic        dot,
    output logic [3:0]  rows,
    input  logic [3:0]  cols
);

    logic [31:0] display_din;
    logic [7:0]  key_reg;
    logic [7:0]  rd_data;
    logic [31:0] magnitude;
    logic [39:0] bcd;
    logic [6:0]  digit_seg [10];
    logic [3:0]  nib;
    logic        seen;

    peripheral_controller_keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) u_keypad_scanner (
        .clk     (clk),
        .reset   (reset),
        .cols    (cols),
        .rows    (rows),
        .key_reg (key_reg)
    );

    always_comb begin
        rd_data = 8'h00;
        case (address)
            ADDR_KEY:  rd_data = key_reg;
            ADDR_DISP: rd_data = display_din[7:0];
            default:   rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            display_din <= 32'h0;
            dout        <= 8'h00;
        end else begin
            if (writeEnable && (address == ADDR_DISP)) begin
                display_din <= din;
            end
            dout <= rd_data;
        end
    end

    // Two's-complement negate; 32'h8000_0000 maps onto itself, which is the
    // correct unsigned magnitude 2147483648.
    always_comb begin
        magnitude = display_din[31] ? (~display_din + 32'd1) : display_din;
    end

    // Shift-add-3 binary to BCD, ten digits.
    always_comb begin
        bcd = '0;
        for (int i = 31; i >= 0; i--) begin
            for (int d = 0; d < 10; d++) begin
                if (bcd[4*d +: 4] >= 4'd5) begin
                    bcd[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
                end
            end
            bcd = {bcd[38:0], magnitude[i]};
        end
    end

    // Walk from the most significant digit down; a digit is lit once any digit at
    // or above it is nonzero, and the units digit is always lit.
    always_comb begin
        seen = 1'b0;
        nib  = 4'd0;
        for (int d = 9; d >= 0; d--) begin
            nib  = bcd[4*d +: 4];
            seen = seen | (nib != 4'd0) | (d == 0);
            digit_seg[d] = seen ? ~seg_encode(nib) : ~SEG_BLANK;
        end
    end

    assign hex0  = digit_seg[0];
    assign hex1  = digit_seg[1];
    assign hex2  = digit_seg[2];
    assign hex3  = digit_seg[3];
    assign hex4  = digit_seg[4];
    assign hex5  = digit_seg[5];
    assign hex6  = digit_seg[6];
    assign hex7  = digit_seg[7];
    assign hex8  = digit_seg[8];
    assign hex9  = digit_seg[9];
    assign hex10 = display_din[31] ? ~SEG_MINUS : ~SEG_BLANK;
    assign dot   = 1'b1;

endmodule

// File: tb/tb_peripheral_controller.sv
// Self-checking bench for peripheral_controller: table-driven bus/display vectors
// plus hand-written reset and keypad sequences.
module tb_peripheral_controller;

    localparam int unsigned SCAN_DIV       = 16;
    localparam int unsigned DEBOUNCE_SCANS = 4;
    localparam int unsigned SCAN_CYCLES    = 4 * SCAN_DIV;

    logic        clk;
    logic        reset;
    logic [3:0]  address;
    logic [31:0] din;
    logic        writeEnable;
    logic [7:0]  dout;
    logic [6:0]  hex0, hex1, hex2, hex3, hex4, hex5, hex6, hex7, hex8, hex9, hex10;
    logic        dot;
    logic [3:0]  rows;
    logic [3:0]  cols;
    logic [15:0] key_mat;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic        we;
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [3:0]  raddr;
        logic [7:0]  exp_dout;
        logic [87:0] exp_disp;  // 11 chars, leftmost is hex10, rightmost is hex0
    } vec_t;

    vec_t vecs [13];

    peripheral_controller #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .address     (address),
        .din         (din),
        .writeEnable (writeEnable),
        .dout        (dout),
        .hex0        (hex0),
        .hex1        (hex1),
        .hex2        (hex2),
        .hex3        (hex3),
        .hex4        (hex4),
        .hex5        (hex5),
        .hex6        (hex6),
        .hex7        (hex7),
        .hex8        (hex8),
        .hex9        (hex9),
        .hex10       (hex10),
        .dot         (dot),
        .rows        (rows),
        .cols        (cols)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: key r*4+c closes column c while row r is driven.
    always_comb begin
        cols = 4'b0000;
        for (int r = 0; r < 4; r++) begin
            if (rows[r]) cols = cols | key_mat[4*r +: 4];
        end
    end

    function automatic logic [6:0] char_seg(input logic [7:0] c);
        logic [6:0] s;
        case (c)
            "0":     s = ~7'h3F;
            "1":     s = ~7'h06;
            "2":     s = ~7'h5B;
            "3":     s = ~7'h4F;
            "4":     s = ~7'h66;
            "5":     s = ~7'h6D;
            "6":     s = ~7'h7D;
            "7":     s = ~7'h07;
            "8":     s = ~7'h7F;
            "9":     s = ~7'h6F;
            "-":     s = ~7'b1000000;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    task automatic check8(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_disp(input string name, input logic [87:0] exp_str);
        logic [76:0] got;
        logic [76:0] exp;
        got = {hex10, hex9, hex8, hex7, hex6, hex5, hex4, hex3, hex2, hex1, hex0};
        for (int k = 0; k < 11; k++) exp[7*k +: 7] = char_seg(exp_str[8*k +: 8]);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: display got %h expected %h (\"%s\")", name, got, exp, exp_str);
        end
    endtask

    task automatic wait_dout(input string name, input logic [7:0] exp, input int budget);
        int  n;
        bit  hit;
        n   = 0;
        hit = 1'b0;
        while (!hit && n < budget) begin
            @(negedge clk);
            if (dout === exp) hit = 1'b1;
            n++;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s: dout got %h expected %h within %0d cycles", name, dout, exp, budget);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{1'b1, 4'h4, 32'h0000_0012, 4'h4, 8'h12, "         18"};
        vecs[1]  = '{1'b1, 4'h4, 32'hDEAD_BEEF, 4'h4, 8'hEF, "- 559038737"};
        vecs[2]  = '{1'b1, 4'h3, 32'h0000_0055, 4'h4, 8'hEF, "- 559038737"};
        vecs[3]  = '{1'b1, 4'h4, 32'h0000_0000, 4'h7, 8'h00, "          0"};
        vecs[4]  = '{1'b1, 4'h4, 32'h8000_0000, 4'h4, 8'h00, "-2147483648"};
        vecs[5]  = '{1'b1, 4'h4, 32'hFFFF_FFFF, 4'h0, 8'h00, "-         1"};
        vecs[6]  = '{1'b1, 4'h4, 32'h7FFF_FFFF, 4'h4, 8'hFF, " 2147483647"};
        vecs[7]  = '{1'b1, 4'h4, 32'h3B9A_CA00, 4'h4, 8'h00, " 1000000000"};
        vecs[8]  = '{1'b1, 4'h4, 32'h0000_0389, 4'hF, 8'h00, "        905"};
        vecs[9]  = '{1'b0, 4'h4, 32'h0000_1234, 4'h4, 8'h89, "        905"};
        vecs[10] = '{1'b1, 4'h4, 32'hFFFF_FC77, 4'h4, 8'h77, "-       905"};
        vecs[11] = '{1'b1, 4'h4, 32'h0000_000A, 4'h4, 8'h0A, "         10"};
        vecs[12] = '{1'b1, 4'h5, 32'h0000_00FF, 4'h3, 8'h00, "         10"};

        reset       = 1'b0;
        writeEnable = 1'b0;
        address     = 4'h4;
        din         = 32'h0;
        key_mat     = 16'h0;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check8("reset_dout", dout, 8'h00);
        check_disp("reset_disp", "          0");
        check8("reset_dot", {7'b0, dot}, 8'h01);
        check8("reset_rows", {4'b0, rows}, 8'h01);

        // Release; rows advance exactly SCAN_DIV cycles later
        reset = 1'b1;
        repeat (SCAN_DIV - 1) @(posedge clk);
        @(negedge clk);
        check8("rows_hold", {4'b0, rows}, 8'h01);
        check8("post_reset_dout", dout, 8'h00);
        @(posedge clk);
        @(negedge clk);
        check8("rows_step", {4'b0, rows}, 8'h02);

        // Bus and display vectors
        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            writeEnable = vecs[i].we;
            address     = vecs[i].addr;
            din         = vecs[i].wdata;
            @(negedge clk);
            writeEnable = 1'b0;
            address     = vecs[i].raddr;
            @(negedge clk);
            check8($sformatf("vec%0d_dout", i), dout, vecs[i].exp_dout);
            check_disp($sformatf("vec%0d_disp", i), vecs[i].exp_disp);
        end

        // Reset mid-operation wins over a simultaneous write
        @(negedge clk);
        writeEnable = 1'b1;
        address     = 4'h4;
        din         = 32'h0000_0099;
        reset       = 1'b0;
        @(negedge clk);
        writeEnable = 1'b0;
        reset       = 1'b1;
        @(negedge clk);
        check8("midreset_dout", dout, 8'h00);
        check_disp("midreset_disp", "          0");

        // Keypad: row 1, column 2 -> code 6
        address = 4'h0;
        key_mat = 16'h0040;
        repeat (2 * SCAN_CYCLES) @(posedge clk);
        @(negedge clk);
        check8("key_early", dout, 8'h00);
        wait_dout("key6_accept", 8'h86, 8 * SCAN_CYCLES);
        key_mat = 16'h0000;
        wait_dout("key6_release", 8'h00, 8 * SCAN_CYCLES);

        // Two keys: codes 7 and 8 held together, lowest wins
        key_mat = 16'h0180;
        wait_dout("key_multi", 8'h87, 8 * SCAN_CYCLES);
        key_mat = 16'h0000;
        wait_dout("key_multi_release", 8'h00, 8 * SCAN_CYCLES);

        // Corner key: row 3, column 3 -> code 15
        key_mat = 16'h8000;
        wait_dout("key15_accept", 8'h8F, 8 * SCAN_CYCLES);
        address = 4'h4;
        @(negedge clk);
        @(negedge clk);
        check8("key_addr4_dout", dout, 8'h00);
        check_disp("key_disp_unchanged", "          0");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
